bsg_axis_packet_echo: RTL and testbench



---
 rtl/bsg_axis_packet_echo.sv | 149 ++++++++++++++
 tb/tb_bsg_axis_packet_echo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_axis_packet_echo.sv
// Far-end AXI4-Stream echo partner: buffers one fixed-length packet, checks tlast framing,
// then replays it with a registered offset added to every beat.
module bsg_axis_packet_echo #(
   parameter int data_width_p = 32,
   parameter int txn_size_p   = 16
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    clear_i,
   input  logic [data_width_p-1:0] offset_i,

   input  logic [data_width_p-1:0] s_axis_tdata_i,
   input  logic                    s_axis_tvalid_i,
   input  logic                    s_axis_tlast_i,
   output logic                    s_axis_tready_o,

   output logic [data_width_p-1:0] m_axis_tdata_o,
   output logic                    m_axis_tvalid_o,
   output logic                    m_axis_tlast_o,
   input  logic                    m_axis_tready_i,

   output logic                    err_o,
   output logic [31:0]             pkt_count_o
);

   localparam int cnt_width_lp = $clog2(txn_size_p + 1);
   localparam int idx_width_lp = $clog2(txn_size_p);
   localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(txn_size_p - 1);

   typedef enum logic [1:0] {
      eRecv  = 2'd0,
      eDrain = 2'd1,
      eSend  = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
   logic                      err_q, err_d;
   logic [31:0]               pkt_count_q, pkt_count_d;
   logic [data_width_p-1:0]   off_q, off_d;
   logic [data_width_p-1:0]   buf_q [txn_size_p];
   logic [idx_width_lp-1:0]   idx;
   logic                      in_hs, out_hs, wipe;

   assign wipe   = reset_i | clear_i;
   assign in_hs  = s_axis_tvalid_i & s_axis_tready_o;
   assign out_hs = m_axis_tvalid_o & m_axis_tready_i;
   assign idx    = cnt_q[idx_width_lp-1:0];

   always_ff @(posedge clk_i) begin
      if (wipe) begin
         state_q     <= eRecv;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         pkt_count_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         pkt_count_q <= pkt_count_d;
         off_q       <= off_d;
      end
   end

   // Packet store; contents are deliberately left unreset.
   always_ff @(posedge clk_i) begin
      if (!wipe && (state_q == eRecv) && in_hs) begin
         buf_q[idx] <= s_axis_tdata_i;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      pkt_count_d = pkt_count_q;
      off_d       = off_q;
      case (state_q)
         eRecv: begin
            if (in_hs) begin
               if (cnt_q == last_cnt_lp) begin
                  cnt_d = '0;
                  if (s_axis_tlast_i) begin
                     off_d   = offset_i;
                     state_d = eSend;
                  end else begin
                     err_d   = 1'b1;
                     state_d = eDrain;
                  end
               end else if (s_axis_tlast_i) begin
                  // early last: drop the partial packet and resynchronise
                  err_d = 1'b1;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + cnt_width_lp'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         eDrain: begin
            if (in_hs && s_axis_tlast_i) begin
               cnt_d   = '0;
               state_d = eRecv;
            end else begin
               state_d = eDrain;
            end
         end
         eSend: begin
            if (out_hs) begin
               if (cnt_q == last_cnt_lp) begin
                  cnt_d       = '0;
                  pkt_count_d = pkt_count_q + 32'd1;
                  state_d     = eRecv;
               end else begin
                  cnt_d = cnt_q + cnt_width_lp'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = eRecv;
            cnt_d   = '0;
         end
      endcase
   end

   // Handshake outputs depend on state and registers only.
   always_comb begin
      s_axis_tready_o = 1'b0;
      m_axis_tvalid_o = 1'b0;
      m_axis_tlast_o  = 1'b0;
      case (state_q)
         eRecv:  s_axis_tready_o = 1'b1;
         eDrain: s_axis_tready_o = 1'b1;
         eSend: begin
            m_axis_tvalid_o = 1'b1;
            m_axis_tlast_o  = (cnt_q == last_cnt_lp);
         end
         default: s_axis_tready_o = 1'b0;
      endcase
   end

   assign m_axis_tdata_o = buf_q[idx] + off_q;
   assign err_o          = err_q;
   assign pkt_count_o    = pkt_count_q;

endmodule

// File: tb/tb_bsg_axis_packet_echo.sv
// Self-checking bench for bsg_axis_packet_echo: packet vector table plus scoreboard of
// expected outbound beats, with hand-written clear and reset sequences.
module tb_bsg_axis_packet_echo;

   localparam int txn_lp = 16;

   logic        clk;
   logic        reset_i, clear_i;
   logic [31:0] offset_i;
   logic [31:0] s_axis_tdata_i;
   logic        s_axis_tvalid_i, s_axis_tlast_i, s_axis_tready_o;
   logic [31:0] m_axis_tdata_o;
   logic        m_axis_tvalid_o, m_axis_tlast_o, m_axis_tready_i;
   logic        err_o;
   logic [31:0] pkt_count_o;

   bsg_axis_packet_echo #(.data_width_p(32), .txn_size_p(txn_lp)) dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .clear_i         (clear_i),
      .offset_i        (offset_i),
      .s_axis_tdata_i  (s_axis_tdata_i),
      .s_axis_tvalid_i (s_axis_tvalid_i),
      .s_axis_tlast_i  (s_axis_tlast_i),
      .s_axis_tready_o (s_axis_tready_o),
      .m_axis_tdata_o  (m_axis_tdata_o),
      .m_axis_tvalid_o (m_axis_tvalid_o),
      .m_axis_tlast_o  (m_axis_tlast_o),
      .m_axis_tready_i (m_axis_tready_i),
      .err_o           (err_o),
      .pkt_count_o     (pkt_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      int unsigned nbeats;
      int unsigned last_pos;
      logic [31:0] base;
      logic [31:0] off;
      int unsigned rdy;
      logic        pre_reset;
      logic        echo;
      logic        exp_err;
      logic [31:0] exp_pkt;
   } vec_t;

   beat_t       exp_q[$];
   vec_t        vecs[7];
   int unsigned rdy_pct;
   int          n_cmp, n_bad;
   logic        stall_q;
   logic [31:0] prev_data;
   logic        prev_last;
   logic        dummy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, wanted %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: entered and left just after a falling edge; samples before the rising edge.
   task automatic tick(output logic ihs);
      beat_t e;
      m_axis_tready_i = ($urandom_range(0, 99) < rdy_pct);
      #1;
      ihs = s_axis_tvalid_i & s_axis_tready_o;
      if (m_axis_tvalid_o) begin
         check1("tready_in_send", s_axis_tready_o, 1'b0);
         if (stall_q) begin
            check("stall_data", m_axis_tdata_o, prev_data);
            check1("stall_last", m_axis_tlast_o, prev_last);
         end
         if (m_axis_tready_i) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_beat: got data %h last %b, wanted no beat", m_axis_tdata_o, m_axis_tlast_o);
            end else begin
               e = exp_q.pop_front();
               check("out_data", m_axis_tdata_o, e.data);
               check1("out_last", m_axis_tlast_o, e.last);
            end
         end
      end
      stall_q   = m_axis_tvalid_o & ~m_axis_tready_i;
      prev_data = m_axis_tdata_o;
      prev_last = m_axis_tlast_o;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      tick(dummy);
      reset_i = 1'b0;
      #1;
      check1("rst_tready", s_axis_tready_o, 1'b1);
      check1("rst_tvalid", m_axis_tvalid_o, 1'b0);
      check1("rst_tlast", m_axis_tlast_o, 1'b0);
      check1("rst_err", err_o, 1'b0);
      check("rst_pkt_count", pkt_count_o, 32'd0);
   endtask

   task automatic send_packet(input int unsigned n, input int unsigned last_pos,
                              input logic [31:0] base, input logic [31:0] off,
                              input logic push, input logic exp_valid);
      logic        ihs;
      int unsigned guard;
      offset_i = off;
      if (push) begin
         for (int i = 0; i < txn_lp; i++) begin
            exp_q.push_back('{data: base + 32'(i) + off, last: (i == txn_lp - 1)});
         end
      end
      for (int i = 0; i < int'(n); i++) begin
         s_axis_tvalid_i = 1'b1;
         s_axis_tdata_i  = base + 32'(i);
         s_axis_tlast_i  = (i == int'(last_pos));
         ihs   = 1'b0;
         guard = 0;
         while (!ihs && guard < 200) begin
            tick(ihs);
            guard++;
         end
         if (!ihs) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_accept: beat %0d not taken within 200 cycles, wanted acceptance", i);
            break;
         end
      end
      s_axis_tvalid_i = 1'b0;
      s_axis_tlast_i  = 1'b0;
      // offset must have been captured already; perturb it to prove that
      offset_i = 32'hDEAD_BEEF;
      #1;
      check1("out_valid_after_last", m_axis_tvalid_o, exp_valid);
   endtask

   task automatic drain();
      int unsigned guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 400) begin
         tick(dummy);
         guard++;
      end
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: %0d beats still pending, wanted 0", exp_q.size());
         exp_q.delete();
      end
      for (int i = 0; i < 4; i++) tick(dummy);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      stall_q = 1'b0;
      prev_data = 32'd0;
      prev_last = 1'b0;
      rdy_pct = 100;
      reset_i = 1'b1;
      clear_i = 1'b0;
      offset_i = 32'd0;
      s_axis_tdata_i = 32'd0;
      s_axis_tvalid_i = 1'b0;
      s_axis_tlast_i = 1'b0;
      m_axis_tready_i = 1'b1;

      //        nbeats last  base           off            rdy  rst   echo  err   pkt
      vecs[0] = '{16, 15, 32'h0000_0000, 32'h0000_0010, 100, 1'b0, 1'b1, 1'b0, 32'd1};
      vecs[1] = '{16, 15, 32'hFFFF_FFF0, 32'h0000_0020,  50, 1'b0, 1'b1, 1'b0, 32'd2};
      vecs[2] = '{ 5,  4, 32'h0000_0100, 32'h0000_0000, 100, 1'b1, 1'b0, 1'b1, 32'd0};
      vecs[3] = '{16, 15, 32'h0000_0200, 32'h0000_0005, 100, 1'b0, 1'b1, 1'b1, 32'd1};
      vecs[4] = '{20, 19, 32'h0000_0300, 32'h0000_0000, 100, 1'b1, 1'b0, 1'b1, 32'd0};
      vecs[5] = '{16, 15, 32'h0000_0400, 32'h0000_0007,  70, 1'b0, 1'b1, 1'b1, 32'd1};
      vecs[6] = '{16, 15, 32'hABCD_0000, 32'hFFFF_0000,  30, 1'b0, 1'b1, 1'b1, 32'd2};

      @(negedge clk);
      do_reset();

      for (int v = 0; v < 7; v++) begin
         if (vecs[v].pre_reset) do_reset();
         rdy_pct = vecs[v].rdy;
         send_packet(vecs[v].nbeats, vecs[v].last_pos, vecs[v].base, vecs[v].off,
                     vecs[v].echo, vecs[v].echo);
         drain();
         check1("vec_err", err_o, vecs[v].exp_err);
         check("vec_pkt_count", pkt_count_o, vecs[v].exp_pkt);
      end

      // clear mid-RECV, with a tlast handshake in the clear cycle that must be ignored
      rdy_pct = 100;
      send_packet(7, 99, 32'h0000_0500, 32'h0000_0000, 1'b0, 1'b0);
      clear_i = 1'b1;
      s_axis_tvalid_i = 1'b1;
      s_axis_tdata_i = 32'h5555_5555;
      s_axis_tlast_i = 1'b1;
      tick(dummy);
      clear_i = 1'b0;
      s_axis_tvalid_i = 1'b0;
      s_axis_tlast_i = 1'b0;
      #1;
      check1("clr_err", err_o, 1'b0);
      check("clr_pkt_count", pkt_count_o, 32'd0);
      check1("clr_tready", s_axis_tready_o, 1'b1);
      send_packet(16, 15, 32'h0000_0600, 32'h0000_0003, 1'b1, 1'b1);
      drain();
      check("clr_then_pkt_count", pkt_count_o, 32'd1);
      check1("clr_then_err", err_o, 1'b0);

      // reset mid-SEND while the sink stalls
      rdy_pct = 0;
      send_packet(16, 15, 32'h0000_0700, 32'h0000_0001, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick(dummy);
      check1("stalled_valid", m_axis_tvalid_o, 1'b1);
      do_reset();
      rdy_pct = 100;
      send_packet(16, 15, 32'h0000_0800, 32'h0000_0009, 1'b1, 1'b1);
      drain();
      check("post_rst_pkt_count", pkt_count_o, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
